mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  launch request; driven by the control unit's lhr_wen (MULT/MULTU/DIV/DIVU decoded).
REQ-005 md_is_mult  input  1  1 = multiply, 0 = divide; sampled with start.
REQ-006 md_is_unsigned  input  1  1 = unsigned operands (MULTU/DIVU), 0 = signed; sampled with start.
REQ-007 op_a  input  32  rs value (multiplicand / dividend); sampled with start.
REQ-008 op_b  input  32  rt value (multiplier / divisor); sampled with start.
REQ-009 lhr_ren  input  1  MFHI/MFLO read request.
REQ-010 lhr_is_hi  input  1  1 = read HI, 0 = read LO.
REQ-011 rdata  output  32  lhr_is_hi ? HI : LO, combinational.
REQ-012 busy  output  1  operation in progress.
REQ-013 stall  output  1  busy & (lhr_ren | start); datapath holds PC/instruction while high.
REQ-014 hi, lo  output  32 each  architectural HI/LO register contents.

Function
REQ-015 FSM states: IDLE, RUN; 5-bit iteration counter cnt.
REQ-016 IDLE: start=1 at edge k latches op_a, op_b, md_is_mult, md_is_unsigned, goes to RUN, cnt=0; start=0 stays IDLE.
REQ-017 RUN: one iteration per cycle, cnt increments; on edge with cnt=31, HI/LO are written and FSM returns to IDLE.
REQ-018 busy=1 exactly in RUN (cycles k+1..k+32); new HI/LO visible from cycle k+33; HI/LO hold old values while busy.
REQ-019 Operand/op inputs changing during RUN have no effect.
REQ-020 start asserted while busy is ignored (no relaunch, no queueing); stall=1 for that cycle.
REQ-021 Multiply: radix-2 shift-add on magnitudes; 64-bit product; HI = product[63:32], LO = product[31:0].
REQ-022 Divide: restoring shift-subtract on magnitudes; LO = quotient, HI = remainder.
REQ-023 Signed: operands converted to magnitude at launch; product and quotient negated when operand signs differ; remainder takes the sign of the dividend.
REQ-024 Signed -2^31 / -1: LO = 32'h8000_0000, HI = 0; no exception.
REQ-025 Signed product -2^31 * -2^31: HI = 32'h4000_0000, LO = 0.
REQ-026 Divisor = 0 (signed or unsigned): full 32-cycle latency; LO = 32'hFFFF_FFFF, HI = op_a as latched.
REQ-027 rdata valid when stall=0; during busy with lhr_ren=1, stall=1 until the cycle HI/LO update is visible.
REQ-028 No arithmetic exception outputs; MULT/DIV never trap.

Reset
REQ-029 rst=1 at any edge: state=IDLE, cnt=0, busy=0, HI=LO=0, internal operand/accumulator registers cleared; an in-flight operation is aborted and produces no HI/LO write.
REQ-030 rst has priority over start in the same cycle.

Verification
REQ-031 MULTU 0xFFFF_FFFF * 0xFFFF_FFFF -> busy high 32 cycles; at k+33 HI=0xFFFF_FFFE, LO=0x0000_0001.
REQ-032 MULT -3 * 7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; DIV -7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 7 / 2 -> LO=3, HI=1.
REQ-033 DIVU 5 / 0 -> LO=0xFFFF_FFFF, HI=0x0000_0005 after 32 busy cycles; DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
REQ-034 MFHI issued at k+1 of a MULT -> stall=1 for cycles k+1..k+32, rdata equals new HI at k+33 with stall=0; second start at k+5 ignored, result unaffected.
REQ-035 rst pulsed at RUN cnt=10 -> next cycle busy=0, HI=LO=0, stall=0; subsequent MULTU 2*3 -> LO=6, HI=0.
REQ-036 Operand change mid-RUN (op_a, op_b toggled every cycle) -> result matches operands latched at start.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: 32-cycle radix-2 shift-add multiply and restoring divide.
// Results land in HI/LO on the last iteration; reads stall while the unit is busy.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        md_is_mult,
  input  logic        md_is_unsigned,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        lhr_ren,
  input  logic        lhr_is_hi,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; HI/LO stable
  // RUN   | one iteration per cycle, cnt 0..31; HI/LO written on cnt=31
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        mult_q;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic        div_zero_q;
  logic [31:0] raw_a_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q, lo_q;

  logic        launch, finish;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;

  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        ge;
  logic [63:0] acc_next;
  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic [31:0] hi_res, lo_res;

  assign launch = (state_q == IDLE) && start;
  assign finish = (state_q == RUN) && (cnt_q == 5'd31);

  assign sign_a = ~md_is_unsigned & op_a[31];
  assign sign_b = ~md_is_unsigned & op_b[31];
  assign mag_a  = sign_a ? (~op_a + 32'd1) : op_a;
  assign mag_b  = sign_b ? (~op_b + 32'd1) : op_b;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration of either algorithm; opnd_q is the multiplicand or the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh   = {acc_q[63:32], acc_q[31]};
    diff     = rem_sh - {1'b0, opnd_q};
    ge       = ~diff[32];
    acc_next = 64'd0;
    if (mult_q) begin
      acc_next = {mul_sum, acc_q[31:1]};
    end else begin
      acc_next = {(ge ? diff[31:0] : rem_sh[31:0]), acc_q[30:0], ge};
    end
  end

  always_comb begin
    prod   = neg_res_q ? (~acc_next + 64'd1) : acc_next;
    quot   = neg_res_q ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    rem    = neg_rem_q ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
    hi_res = rem;
    lo_res = quot;
    if (mult_q) begin
      hi_res = prod[63:32];
      lo_res = prod[31:0];
    end else if (div_zero_q) begin
      hi_res = raw_a_q;
      lo_res = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 5'd0;
      mult_q     <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      raw_a_q    <= 32'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 64'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else if (launch) begin
      cnt_q      <= 5'd0;
      mult_q     <= md_is_mult;
      neg_res_q  <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
      div_zero_q <= ~md_is_mult && (op_b == 32'd0);
      raw_a_q    <= op_a;
      opnd_q     <= md_is_mult ? mag_a : mag_b;
      acc_q      <= md_is_mult ? {32'd0, mag_b} : {32'd0, mag_a};
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 5'd1;
      acc_q <= acc_next;
      if (finish) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = busy & (lhr_ren | start);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = lhr_is_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency, stall and reset abort.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        md_is_mult;
  logic        md_is_unsigned;
  logic [31:0] op_a, op_b;
  logic        lhr_ren;
  logic        lhr_is_hi;
  logic [31:0] rdata;
  logic        busy;
  logic        stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] prev_hi, prev_lo;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .md_is_mult(md_is_mult),
    .md_is_unsigned(md_is_unsigned), .op_a(op_a), .op_b(op_b),
    .lhr_ren(lhr_ren), .lhr_is_hi(lhr_is_hi), .rdata(rdata),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic ok,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch, scramble operands while running, and verify latency and held HI/LO.
  task automatic run_op(input string tag, input logic mult, input logic uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    prev_hi = hi;
    prev_lo = lo;
    @(negedge clk);
    start = 1'b1; md_is_mult = mult; md_is_unsigned = uns; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      op_a = $urandom;
      op_b = $urandom;
      md_is_mult = ~md_is_mult;
      md_is_unsigned = ~md_is_unsigned;
      if (n == 16) begin
        check({tag, "_hold_hi"}, hi === prev_hi, hi, prev_hi);
        check({tag, "_hold_lo"}, lo === prev_lo, lo, prev_lo);
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n == 32, n, 32);
    check({tag, "_hi"}, hi === exp_hi, hi, exp_hi);
    check({tag, "_lo"}, lo === exp_lo, lo, exp_lo);
    lhr_is_hi = 1'b1;
    #1;
    check({tag, "_rdata_hi"}, rdata === exp_hi, rdata, exp_hi);
    lhr_is_hi = 1'b0;
    #1;
    check({tag, "_rdata_lo"}, rdata === exp_lo, rdata, exp_lo);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; md_is_mult = 1'b0; md_is_unsigned = 1'b0;
    op_a = 32'd0; op_b = 32'd0; lhr_ren = 1'b0; lhr_is_hi = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy === 1'b0, busy, 1'b0);
    check("reset_hi", hi === 32'd0, hi, 32'd0);
    check("reset_lo", lo === 32'd0, lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", stall === 1'b0, stall, 1'b0);

    run_op("multu_max", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x7", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_m7d2", 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7d2", 1'b0, 1'b1, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("divu_5d0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_min_m1", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("mult_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_op("div_m5d0", 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_100dm7", 1'b0, 1'b0, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

    // MFHI right behind a MULT, with an ignored second start at k+5.
    @(negedge clk);
    start = 1'b1; md_is_mult = 1'b1; md_is_unsigned = 1'b0; op_a = 32'h0000_1234; op_b = 32'hFFFF_FFFB;
    n = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      start = (i == 5);
      op_a = 32'd9; op_b = 32'd9;
      lhr_ren = 1'b1; lhr_is_hi = 1'b1;
      #1;
      if (stall) n++;
    end
    check("mfhi_stall_cycles", n == 32, n, 32);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("mfhi_stall_done", stall === 1'b0, stall, 1'b0);
    check("mfhi_busy_done", busy === 1'b0, busy, 1'b0);
    check("mfhi_rdata", rdata === 32'hFFFF_FFFF, rdata, 32'hFFFF_FFFF);
    check("mfhi_lo", lo === 32'hFFFF_A4FC, lo, 32'hFFFF_A4FC);
    lhr_ren = 1'b0;

    // Reset abort at cnt=10 (cycle k+11).
    @(negedge clk);
    start = 1'b1; md_is_mult = 1'b1; md_is_unsigned = 1'b1; op_a = 32'd100; op_b = 32'd100;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lhr_ren = 1'b1;
    #1;
    check("abort_busy", busy === 1'b0, busy, 1'b0);
    check("abort_hi", hi === 32'd0, hi, 32'd0);
    check("abort_lo", lo === 32'd0, lo, 32'd0);
    check("abort_stall", stall === 1'b0, stall, 1'b0);
    lhr_ren = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_write", lo === 32'd0, lo, 32'd0);
    run_op("multu_2x3", 1'b1, 1'b1, 32'd2, 32'd3, 32'd0, 32'd6);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; md_is_mult = 1'b1; op_a = 32'd4; op_b = 32'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_over_start_busy", busy === 1'b0, busy, 1'b0);
    check("rst_over_start_lo", lo === 32'd0, lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
